// File: rtl/serial_adder.sv
// Bit-serial adder: operands are loaded in parallel, then summed LSB-first,
// one bit per enabled clock, through a single full adder and a carry flop.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pload,
  input  logic [WIDTH-1:0] adata,
  input  logic [WIDTH-1:0] bdata,
  input  logic             enable,
  output logic [WIDTH-1:0] pout,
  output logic             cout,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_done;

  logic             w_sum;
  logic             w_carry;

  assign w_sum   = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else if (pload) begin
      r_a     <= adata;
      r_b     <= bdata;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else if (enable && !r_done) begin
      // Sum bit enters at the MSB so the final LSB lands at bit 0 after WIDTH steps.
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_s     <= {w_sum, r_s[WIDTH-1:1]};
      r_carry <= w_carry;
      r_cnt   <= r_cnt + CW'(1);
      r_done  <= (r_cnt == LAST);
    end
  end

  assign pout = r_s;
  assign cout = r_carry;
  assign done = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus randomized
// operations with pauses, checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pload = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] adata = '0;
  logic [W-1:0] bdata = '0;
  logic [W-1:0] pout;
  logic         cout;
  logic         done;

  int total = 0;
  int bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .pload(pload), .adata(adata), .bdata(bdata),
    .enable(enable), .pout(pout), .cout(cout), .done(done)
  );

  always #5 clk = ~clk;

  // Drive one clock with the given strobes; return 1 ns after the rising edge.
  task automatic cyc(input logic pl, input logic en);
    pload = pl;
    enable = en;
    @(posedge clk);
    #1;
    pload = 1'b0;
    enable = 1'b0;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    adata = a;
    bdata = b;
    cyc(1'b1, 1'b0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
  endtask

  // Reference: after k steps the top k bits of pout are the low k bits of a+b.
  function automatic logic [W-1:0] partial(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    logic [W:0]     full;
    logic [2*W-1:0] low;
    full = {1'b0, a} + {1'b0, b};
    if (k >= W) return full[W-1:0];
    low = (2*W)'(full[W-1:0]) & (((2*W)'(1) << k) - (2*W)'(1));
    low = low << (W - k);
    return low[W-1:0];
  endfunction

  function automatic logic carry_of(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[W];
  endfunction

  task automatic test_reset;
    total++; if (pout !== '0) begin bad++; $display("FAIL reset_pout got=%h exp=00", pout); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    steps(W - 1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL noload_early_done got=%b exp=0", done); end
    steps(1);
    total++; if (done !== 1'b1 || pout !== '0) begin bad++; $display("FAIL noload_done got=%b/%h exp=1/00", done, pout); end
    load(8'hAA, 8'h55);
    steps(3);
    enable = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    total++; if (pout !== '0) begin bad++; $display("FAIL async_pout got=%h exp=00", pout); end
    total++; if (cout !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL async_flags got=%b/%b exp=0/0", cout, done); end
    enable = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    load(8'hAA, 8'h55);
    steps(4);
    total++; if (pout !== 8'hF0 || done !== 1'b0) begin bad++; $display("FAIL basic_half got=%h/%b exp=f0/0", pout, done); end
    steps(4);
    total++; if (pout !== 8'hFF || cout !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL basic_full got=%h/%b/%b exp=ff/0/1", pout, cout, done); end
  endtask

  task automatic test_carry;
    load(8'hFF, 8'h01);
    steps(W);
    total++; if (pout !== 8'h00 || cout !== 1'b1 || done !== 1'b1) begin bad++; $display("FAIL carry_ff01 got=%h/%b/%b exp=00/1/1", pout, cout, done); end
    load(8'h80, 8'h80);
    steps(W);
    total++; if (pout !== 8'h00 || cout !== 1'b1) begin bad++; $display("FAIL carry_8080 got=%h/%b exp=00/1", pout, cout); end
  endtask

  task automatic test_pause;
    load(8'h3C, 8'h0F);
    steps(3);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0);
      total++; if (done !== 1'b0 || pout !== 8'h60) begin bad++; $display("FAIL pause_hold got=%h/%b exp=60/0", pout, done); end
    end
    steps(5);
    total++; if (pout !== 8'h4B || cout !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL pause_result got=%h/%b/%b exp=4b/0/1", pout, cout, done); end
  endtask

  task automatic test_priority;
    adata = 8'h12;
    bdata = 8'h34;
    cyc(1'b1, 1'b1);
    total++; if (pout !== 8'h00 || done !== 1'b0) begin bad++; $display("FAIL prio_load got=%h/%b exp=00/0", pout, done); end
    steps(W - 1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL prio_count got=%b exp=0", done); end
    steps(1);
    total++; if (pout !== 8'h46 || done !== 1'b1) begin bad++; $display("FAIL prio_result got=%h/%b exp=46/1", pout, done); end
    steps(4);
    total++; if (pout !== 8'h46 || done !== 1'b1 || cout !== 1'b0) begin bad++; $display("FAIL hold_after_done got=%h/%b/%b exp=46/1/0", pout, done, cout); end
  endtask

  task automatic test_reload;
    load(8'hAA, 8'h55);
    steps(5);
    load(8'h01, 8'h01);
    total++; if (pout !== 8'h00 || done !== 1'b0) begin bad++; $display("FAIL reload_clear got=%h/%b exp=00/0", pout, done); end
    steps(W);
    total++; if (pout !== 8'h02 || done !== 1'b1) begin bad++; $display("FAIL reload_result got=%h/%b exp=02/1", pout, done); end
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int k;
    for (int op = 0; op < 25; op++) begin
      a = W'($urandom);
      b = W'($urandom);
      load(a, b);
      k = 0;
      while (k < W) begin
        if ($urandom_range(3) != 0) begin
          cyc(1'b0, 1'b1);
          k++;
        end else begin
          cyc(1'b0, 1'b0);
        end
        total++;
        if (pout !== partial(a, b, k) || done !== (k == W)) begin
          bad++;
          $display("FAIL rand_step op=%0d k=%0d got=%h/%b exp=%h/%b", op, k, pout, done, partial(a, b, k), (k == W));
        end
      end
      steps($urandom_range(2));
      total++;
      if (pout !== partial(a, b, W) || cout !== carry_of(a, b) || done !== 1'b1) begin
        bad++;
        $display("FAIL rand_final a=%h b=%h got=%h/%b exp=%h/%b", a, b, pout, cout, partial(a, b, W), carry_of(a, b));
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_basic();
    test_carry();
    test_pause();
    test_priority();
    test_reload();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
